// File: rtl/ddr_init_wr_ctrl.sv
// Turns the 161-bit DDR-init instruction stream into single-beat MIG UI writes.
// A 64-deep FIFO absorbs the producer; an IDLE/LOAD/ISSUE/RETIRE sequencer drains it.
module ddr_init_wr_ctrl #(
  parameter int FIFO_AW    = 6,
  parameter int ADDR_SHIFT = 3
) (
  input  logic               clk_200M,
  input  logic               rst,
  input  logic               ins_vld,
  input  logic [160:0]       ins,
  input  logic               init_calib_complete,
  output logic [27:0]        app_addr,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  input  logic               app_rdy,
  output logic [127:0]       app_wdf_data,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  output logic [15:0]        app_wdf_mask,
  input  logic               app_wdf_rdy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               fifo_overflow,
  output logic               ddr_init_done
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ISSUE = 2'd2, RETIRE = 2'd3} state_e;

  logic [160:0]       mem [DEPTH];
  state_e             state_q, state_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               overflow_q, overflow_d, done_q, done_d;
  logic               hold_fin_q, hold_fin_d;
  logic [127:0]       hold_data_q, hold_data_d;
  logic [27:0]        hold_addr_q, hold_addr_d;
  logic [3:0]         hold_bl_q, hold_bl_d;
  logic [27:0]        app_addr_q, app_addr_d;
  logic [127:0]       wdf_data_q, wdf_data_d;
  logic               app_en_q, app_en_d, wren_q, wren_d;
  logic               push_s, pop_s;
  logic [160:0]       head_s;

  // Next-state logic for the FIFO bookkeeping and the write sequencer.
  always_comb begin
    push_s      = ins_vld && (level_q != LVL_FULL);
    pop_s       = (state_q == IDLE) && (level_q != LVL_ZERO) && init_calib_complete;
    head_s      = mem[rd_ptr_q];
    wr_ptr_d    = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d     = level_q + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};
    overflow_d  = overflow_q || (ins_vld && !push_s);
    state_d     = state_q;
    done_d      = done_q;
    hold_fin_d  = hold_fin_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    hold_bl_d   = hold_bl_q;
    app_addr_d  = app_addr_q;
    wdf_data_d  = wdf_data_q;
    app_en_d    = app_en_q;
    wren_d      = wren_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d     = LOAD;
          hold_fin_d  = head_s[160];
          hold_data_d = head_s[159:32];
          hold_addr_d = head_s[31:4];
          hold_bl_d   = head_s[3:0];
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // bl==0 entries are fillers: they retire without touching the MIG.
        if (hold_bl_q == 4'd0) begin
          state_d = RETIRE;
        end else begin
          state_d    = ISSUE;
          app_en_d   = 1'b1;
          wren_d     = 1'b1;
          app_addr_d = hold_addr_q << ADDR_SHIFT;
          wdf_data_d = hold_data_q;
        end
      end
      ISSUE: begin
        if (app_en_q && app_rdy) begin
          app_en_d = 1'b0;
        end else begin
          app_en_d = app_en_q;
        end
        if (wren_q && app_wdf_rdy) begin
          wren_d = 1'b0;
        end else begin
          wren_d = wren_q;
        end
        if (!app_en_d && !wren_d) begin
          state_d = RETIRE;
        end else begin
          state_d = ISSUE;
        end
      end
      RETIRE: begin
        state_d = IDLE;
        if (hold_fin_q) begin
          done_d = 1'b1;
        end else begin
          done_d = done_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk_200M) begin
    if (push_s) begin
      mem[wr_ptr_q] <= ins;
    end
  end

  // State, FIFO pointers and registered MIG outputs.
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {FIFO_AW{1'b0}};
      rd_ptr_q    <= {FIFO_AW{1'b0}};
      level_q     <= LVL_ZERO;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      hold_fin_q  <= 1'b0;
      hold_data_q <= 128'd0;
      hold_addr_q <= 28'd0;
      hold_bl_q   <= 4'd0;
      app_addr_q  <= 28'd0;
      wdf_data_q  <= 128'd0;
      app_en_q    <= 1'b0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      hold_fin_q  <= hold_fin_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      hold_bl_q   <= hold_bl_d;
      app_addr_q  <= app_addr_d;
      wdf_data_q  <= wdf_data_d;
      app_en_q    <= app_en_d;
      wren_q      <= wren_d;
    end
  end

  assign app_addr      = app_addr_q;
  assign app_cmd       = 3'b000;
  assign app_en        = app_en_q;
  assign app_wdf_data  = wdf_data_q;
  assign app_wdf_wren  = wren_q;
  assign app_wdf_end   = wren_q;
  assign app_wdf_mask  = 16'h0000;
  assign fifo_level    = level_q;
  assign fifo_overflow = overflow_q;
  assign ddr_init_done = done_q;
endmodule
